// File: rtl/vision_pkg.sv
`default_nettype none
// ============================================================================
// vision_pkg : shared FSM state, hue range and frame-geometry widths
// Rev 1.0
// ============================================================================
package vision_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int HUE_MAX   = 360;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  function automatic int x_width(input int img_w);
    return $clog2(img_w);
  endfunction

  function automatic int y_width(input int img_h);
    return $clog2(img_h);
  endfunction

  function automatic int cnt_width(input int img_w, input int img_h);
    return $clog2(img_w * img_h + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hue_window_match.sv
`default_nettype none
// ============================================================================
// hue_window_match : combinational in-window test, window may wrap through 0
// Rev 1.0
// ============================================================================
module hue_window_match
  import vision_pkg::*;
#(
  parameter int PRECISION = 16,
  parameter int HUE_LO    = 0,
  parameter int HUE_HI    = 20
) (
  input  logic [PRECISION-1:0] hue,
  output logic                 match
);

  localparam logic [PRECISION-1:0] c_lo  = PRECISION'(HUE_LO);
  localparam logic [PRECISION-1:0] c_hi  = PRECISION'(HUE_HI);

  logic w_ge_lo;
  logic w_le_hi;
  logic w_in_range;

  // Constant comparisons are folded away so narrow inputs stay lint-clean
  generate
    if (HUE_LO == 0) begin : g_lo_zero
      assign w_ge_lo = 1'b1;
    end else begin : g_lo_cmp
      assign w_ge_lo = (hue >= c_lo);
    end

    if ((2 ** PRECISION) <= HUE_MAX) begin : g_all_legal
      assign w_in_range = 1'b1;
    end else begin : g_range_cmp
      localparam logic [PRECISION-1:0] c_max = PRECISION'(HUE_MAX);
      assign w_in_range = (hue < c_max);
    end
  endgenerate

  assign w_le_hi = (hue <= c_hi);

  generate
    if (HUE_LO <= HUE_HI) begin : g_plain
      assign match = w_in_range && w_ge_lo && w_le_hi;
    end else begin : g_wrap
      assign match = w_in_range && (w_ge_lo || w_le_hi);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hue_bbox_tracker.sv
`default_nettype none
// ============================================================================
// hue_bbox_tracker : per-frame bounding box and count of in-window hue pixels
// Rev 1.0
// ============================================================================
module hue_bbox_tracker
  import vision_pkg::*;
#(
  parameter int PRECISION  = 16,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int HUE_LO     = 0,
  parameter int HUE_HI     = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic                                 sop,
  input  logic                                 eop,
  input  logic [PRECISION-1:0]                 hue,
  output logic                                 bbox_valid,
  output logic                                 found,
  output logic [x_width(IMG_W)-1:0]            x_min,
  output logic [x_width(IMG_W)-1:0]            x_max,
  output logic [y_width(IMG_H)-1:0]            y_min,
  output logic [y_width(IMG_H)-1:0]            y_max,
  output logic [cnt_width(IMG_W, IMG_H)-1:0]   match_count
);

  localparam int XW = x_width(IMG_W);
  localparam int YW = y_width(IMG_H);
  localparam int CW = cnt_width(IMG_W, IMG_H);

  localparam logic [XW-1:0] c_x_last  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] c_y_last  = YW'(IMG_H - 1);
  localparam logic [CW-1:0] c_cnt_max = '1;
  localparam logic [CW-1:0] c_min_pix = CW'(MIN_PIXELS);

  state_t        r_state, w_state_nxt;
  logic          w_match, w_start, w_pix, w_last, w_zero;
  logic [XW-1:0] r_x, w_px, w_x_nxt;
  logic [YW-1:0] r_y, w_py, w_y_nxt;
  logic [XW-1:0] r_xmin, r_xmax, w_xmin_base, w_xmax_base, w_xmin_nxt, w_xmax_nxt;
  logic [YW-1:0] r_ymin, r_ymax, w_ymin_base, w_ymax_base, w_ymin_nxt, w_ymax_nxt;
  logic [CW-1:0] r_cnt, w_cnt_base, w_cnt_nxt;

  hue_window_match #(
    .PRECISION (PRECISION),
    .HUE_LO    (HUE_LO),
    .HUE_HI    (HUE_HI)
  ) u_match (
    .hue   (hue),
    .match (w_match)
  );

  // A sop restarts the frame from IDLE or ACCUM; REPORT drops everything
  assign w_start = in_valid && sop && (r_state != REPORT);
  assign w_pix   = in_valid && (w_start || (r_state == ACCUM));
  assign w_last  = w_pix && eop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_last) begin
          w_state_nxt = REPORT;
        end else if (w_start) begin
          w_state_nxt = ACCUM;
        end
      end
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_px = w_start ? '0 : r_x;
  assign w_py = w_start ? '0 : r_y;

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_pix) begin
      if (w_px == c_x_last) begin
        w_x_nxt = '0;
        w_y_nxt = (w_py == c_y_last) ? w_py : w_py + YW'(1);
      end else begin
        w_x_nxt = w_px + XW'(1);
        w_y_nxt = w_py;
      end
    end
  end

  always_comb begin
    if (w_start) begin
      w_xmin_base = '1;
      w_xmax_base = '0;
      w_ymin_base = '1;
      w_ymax_base = '0;
      w_cnt_base  = '0;
    end else begin
      w_xmin_base = r_xmin;
      w_xmax_base = r_xmax;
      w_ymin_base = r_ymin;
      w_ymax_base = r_ymax;
      w_cnt_base  = r_cnt;
    end
    w_xmin_nxt = w_xmin_base;
    w_xmax_nxt = w_xmax_base;
    w_ymin_nxt = w_ymin_base;
    w_ymax_nxt = w_ymax_base;
    w_cnt_nxt  = w_cnt_base;
    if (w_pix && w_match) begin
      if (w_cnt_base == '0) begin
        w_xmin_nxt = w_px;
        w_xmax_nxt = w_px;
        w_ymin_nxt = w_py;
        w_ymax_nxt = w_py;
      end else begin
        w_xmin_nxt = (w_px < w_xmin_base) ? w_px : w_xmin_base;
        w_xmax_nxt = (w_px > w_xmax_base) ? w_px : w_xmax_base;
        w_ymin_nxt = (w_py < w_ymin_base) ? w_py : w_ymin_base;
        w_ymax_nxt = (w_py > w_ymax_base) ? w_py : w_ymax_base;
      end
      w_cnt_nxt = (w_cnt_base == c_cnt_max) ? w_cnt_base : w_cnt_base + CW'(1);
    end
  end

  assign w_zero = (w_cnt_nxt == '0);

  // Results are captured on the eop edge so they are visible in the REPORT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_xmin      <= '1;
      r_xmax      <= '0;
      r_ymin      <= '1;
      r_ymax      <= '0;
      r_cnt       <= '0;
      bbox_valid  <= 1'b0;
      found       <= 1'b0;
      x_min       <= '0;
      x_max       <= '0;
      y_min       <= '0;
      y_max       <= '0;
      match_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_xmin     <= w_xmin_nxt;
      r_xmax     <= w_xmax_nxt;
      r_ymin     <= w_ymin_nxt;
      r_ymax     <= w_ymax_nxt;
      r_cnt      <= w_cnt_nxt;
      bbox_valid <= w_last;
      if (w_last) begin
        found       <= (w_cnt_nxt >= c_min_pix);
        x_min       <= w_zero ? '0 : w_xmin_nxt;
        x_max       <= w_zero ? '0 : w_xmax_nxt;
        y_min       <= w_zero ? '0 : w_ymin_nxt;
        y_max       <= w_zero ? '0 : w_ymax_nxt;
        match_count <= w_cnt_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hue_bbox_tracker.sv
`default_nettype none
// ============================================================================
// tb_hue_bbox_tracker : plain and wrapped-window trackers on a 4x2 frame
// Rev 1.0
// ============================================================================
module tb_hue_bbox_tracker;

  localparam int W = 4;
  localparam int H = 2;
  localparam int MINP = 2;
  localparam int CNT_SAT = 15;

  typedef struct { int cnt; int xmin; int xmax; int ymin; int ymax; int found; } res_t;
  typedef struct { int h; bit exp_a; bit exp_w; } mvec_t;

  logic clk = 1'b0;
  logic rst, in_valid, sop, eop;
  logic [15:0] hue;
  logic bv_a, found_a, bv_w, found_w, m_a, m_w;
  logic [1:0] xmin_a, xmax_a, xmin_w, xmax_w;
  logic [0:0] ymin_a, ymax_a, ymin_w, ymax_w;
  logic [3:0] cnt_a, cnt_w;

  int checks = 0;
  int failures = 0;
  int pulses_a = 0;
  int pulses_w = 0;
  mvec_t mt[$];

  always #5 clk = ~clk;

  hue_bbox_tracker #(.PRECISION(16), .IMG_W(W), .IMG_H(H), .HUE_LO(0), .HUE_HI(20),
                     .MIN_PIXELS(MINP)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sop(sop), .eop(eop), .hue(hue),
    .bbox_valid(bv_a), .found(found_a), .x_min(xmin_a), .x_max(xmax_a),
    .y_min(ymin_a), .y_max(ymax_a), .match_count(cnt_a));

  hue_bbox_tracker #(.PRECISION(16), .IMG_W(W), .IMG_H(H), .HUE_LO(340), .HUE_HI(20),
                     .MIN_PIXELS(MINP)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sop(sop), .eop(eop), .hue(hue),
    .bbox_valid(bv_w), .found(found_w), .x_min(xmin_w), .x_max(xmax_w),
    .y_min(ymin_w), .y_max(ymax_w), .match_count(cnt_w));

  hue_window_match #(.PRECISION(16), .HUE_LO(0), .HUE_HI(20)) u_match_a (.hue(hue), .match(m_a));
  hue_window_match #(.PRECISION(16), .HUE_LO(340), .HUE_HI(20)) u_match_w (.hue(hue), .match(m_w));

  always @(negedge clk) begin
    if (bv_a) pulses_a++;
    if (bv_w) pulses_w++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ref_match(input int h, input int lo, input int hi);
    if (h >= 360) return 1'b0;
    if (lo <= hi) return (h >= lo) && (h <= hi);
    return (h >= lo) || (h <= hi);
  endfunction

  // Pixel i of a frame sits at column i mod W, row i div W clamped to the last row
  function automatic res_t ref_frame(input int px[$], input int lo, input int hi);
    res_t r;
    int x, y;
    r = '{default: 0};
    foreach (px[i]) begin
      x = i % W;
      y = i / W;
      if (y > H - 1) y = H - 1;
      if (ref_match(px[i], lo, hi)) begin
        if (r.cnt == 0) begin
          r.xmin = x; r.xmax = x; r.ymin = y; r.ymax = y;
        end else begin
          if (x < r.xmin) r.xmin = x;
          if (x > r.xmax) r.xmax = x;
          if (y < r.ymin) r.ymin = y;
          if (y > r.ymax) r.ymax = y;
        end
        if (r.cnt < CNT_SAT) r.cnt = r.cnt + 1;
      end
    end
    r.found = (r.cnt >= MINP) ? 1 : 0;
    return r;
  endfunction

  task automatic check_out(input string tag, input res_t ea, input res_t ew);
    check({tag, ".a.cnt"},   int'(cnt_a),   ea.cnt);
    check({tag, ".a.found"}, int'(found_a), ea.found);
    check({tag, ".a.xmin"},  int'(xmin_a),  ea.xmin);
    check({tag, ".a.xmax"},  int'(xmax_a),  ea.xmax);
    check({tag, ".a.ymin"},  int'(ymin_a),  ea.ymin);
    check({tag, ".a.ymax"},  int'(ymax_a),  ea.ymax);
    check({tag, ".w.cnt"},   int'(cnt_w),   ew.cnt);
    check({tag, ".w.found"}, int'(found_w), ew.found);
    check({tag, ".w.xmin"},  int'(xmin_w),  ew.xmin);
    check({tag, ".w.xmax"},  int'(xmax_w),  ew.xmax);
    check({tag, ".w.ymin"},  int'(ymin_w),  ew.ymin);
    check({tag, ".w.ymax"},  int'(ymax_w),  ew.ymax);
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input int h);
    @(negedge clk);
    in_valid = v; sop = s; eop = e; hue = 16'(h);
  endtask

  // Optional junk samples in IDLE (no sop) must be ignored; gaps stall the frame
  task automatic send_frame(input int px[$], input int max_gap, input int n_junk, input string tag);
    res_t ea, ew;
    int pa0, pw0;
    ea = ref_frame(px, 0, 20);
    ew = ref_frame(px, 340, 20);
    pa0 = pulses_a;
    pw0 = pulses_w;
    repeat (n_junk) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 10);
    foreach (px[i]) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 400));
      drive(1'b1, i == 0, i == px.size() - 1, px[i]);
    end
    drive(1'b0, 1'b0, 1'b0, 0);
    check({tag, ".bv_a"}, int'(bv_a), 1);
    check({tag, ".bv_w"}, int'(bv_w), 1);
    check_out(tag, ea, ew);
    drive(1'b0, 1'b0, 1'b0, 0);
    #1;
    check({tag, ".bv_a_drop"}, int'(bv_a), 0);
    check({tag, ".hold_cnt_a"}, int'(cnt_a), ea.cnt);
    check({tag, ".pulses_a"}, pulses_a - pa0, 1);
    check({tag, ".pulses_w"}, pulses_w - pw0, 1);
  endtask

  initial begin
    res_t z;
    int px[$];
    int pa0, len, r;
    z = '{default: 0};
    rst = 1'b1; in_valid = 1'b0; sop = 1'b0; eop = 1'b0; hue = '0;
    repeat (3) @(negedge clk);
    check("reset.bv_a", int'(bv_a), 0);
    check("reset.bv_w", int'(bv_w), 0);
    check_out("reset", z, z);
    rst = 1'b0;

    mt.push_back('{0, 1'b1, 1'b1});     mt.push_back('{10, 1'b1, 1'b1});
    mt.push_back('{20, 1'b1, 1'b1});    mt.push_back('{21, 1'b0, 1'b0});
    mt.push_back('{100, 1'b0, 1'b0});   mt.push_back('{339, 1'b0, 1'b0});
    mt.push_back('{340, 1'b0, 1'b1});   mt.push_back('{350, 1'b0, 1'b1});
    mt.push_back('{359, 1'b0, 1'b1});   mt.push_back('{360, 1'b0, 1'b0});
    mt.push_back('{65535, 1'b0, 1'b0});
    foreach (mt[i]) begin
      hue = 16'(mt[i].h);
      #1;
      check($sformatf("match_a.h%0d", mt[i].h), int'(m_a), int'(mt[i].exp_a));
      check($sformatf("match_w.h%0d", mt[i].h), int'(m_w), int'(mt[i].exp_w));
    end

    px = '{100, 10, 100, 100, 100, 100, 10, 100};
    send_frame(px, 0, 0, "two_match");
    check("two_match.const.xmin", int'(xmin_a), 1);
    check("two_match.const.xmax", int'(xmax_a), 2);
    check("two_match.const.ymin", int'(ymin_a), 0);
    check("two_match.const.ymax", int'(ymax_a), 1);
    check("two_match.const.cnt",  int'(cnt_a), 2);
    check("two_match.const.found", int'(found_a), 1);

    px = '{100, 100, 100, 100, 100, 100, 100, 100};
    send_frame(px, 0, 0, "no_match");
    check("no_match.const.cnt", int'(cnt_a), 0);

    px = '{350, 180, 180, 180, 180, 180, 180, 5};
    send_frame(px, 0, 0, "wrapped");
    check("wrapped.const.w.xmax", int'(xmax_w), 3);
    check("wrapped.const.w.cnt", int'(cnt_w), 2);

    drive(1'b1, 1'b1, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b0, 350);
    px = '{100, 100, 10, 100};
    send_frame(px, 0, 0, "restart");
    check("restart.const.xmin", int'(xmin_a), 2);
    check("restart.const.found", int'(found_a), 0);

    pa0 = pulses_a;
    drive(1'b1, 1'b1, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    #1;
    check("midrst.bv_a", int'(bv_a), 0);
    check_out("midrst", z, z);
    drive(1'b0, 1'b0, 1'b0, 0);
    #1;
    check("midrst.pulses", pulses_a - pa0, 0);
    px = '{100, 100, 100, 10, 100, 100, 100, 100};
    send_frame(px, 0, 0, "after_rst");

    px = '{100, 10, 100, 100, 100, 100, 10, 100};
    send_frame(px, 3, 0, "gaps");

    pa0 = pulses_a;
    drive(1'b1, 1'b1, 1'b0, 100);
    drive(1'b1, 1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 1'b1, 10);
    check("report_drop.bv", int'(bv_a), 1);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    #1;
    check("report_drop.pulses", pulses_a - pa0, 1);
    check("report_drop.xmin", int'(xmin_a), 1);
    check("report_drop.cnt", int'(cnt_a), 1);

    for (int f = 0; f < 40; f++) begin
      px.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 3);
        case (r)
          0: px.push_back($urandom_range(0, 400));
          1: px.push_back($urandom_range(0, 25));
          2: px.push_back($urandom_range(335, 365));
          default: px.push_back(100);
        endcase
      end
      send_frame(px, 2, $urandom_range(0, 2), $sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
